frame_stream_rx: RTL and testbench
==================================

FRAME_STREAM_RX -- requirements
Module: frame_stream_rx

Interface
REQ-001 Parameter: H_AP, default 1280, active pixels per line.
REQ-002 Parameter: V_AP, default 720, active lines per frame.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 din_sop  input  1  start of frame; qualified by din_vld.
REQ-006 din_eop  input  1  end of frame; qualified by din_vld.
REQ-007 din_vld  input  1  pixel beat valid; gaps of any length are allowed.
REQ-008 din  input  16  RGB565 pixel.
REQ-009 pix_vld  output  1  accepted pixel valid.
REQ-010 pix_data  output  16  accepted pixel, RGB565.
REQ-011 pix_x  output  11  column of pix_data, 0..H_AP-1.
REQ-012 pix_y  output  10  line of pix_data, 0..V_AP-1.
REQ-013 frame_done  output  1  one-cycle pulse when a complete frame ends correctly.
REQ-014 frame_err  output  1  one-cycle pulse when a framing error is detected.
REQ-015 err_code  output  2  cause of the last error: 01 orphan beat, 10 early sop, 11 eop/length mismatch; held until the next error.
REQ-016 frame_cnt  output  8  count of good frames; wraps 255->0.
REQ-017 busy  output  1  high while in state RECV.

Function
REQ-018 The FSM SHALL have two states: IDLE (waiting for sop) and RECV (frame in progress).
REQ-019 Internal column/line counters (x, y) SHALL advance only on beats that are accepted while din_vld=1; they hold while din_vld=0.
REQ-020 IDLE, beat with din_vld=1 and din_sop=1: accept as pixel (0,0), set x=1/y=0 as the next position, go to RECV.
REQ-021 IDLE, beat with din_vld=1 and din_sop=0: drop (no pix_vld), pulse frame_err, set err_code=01, stay in IDLE.
REQ-022 RECV, din_vld=1, din_sop=0: accept the pixel at the current (x,y); x wraps H_AP-1->0 with y+1.
REQ-023 RECV, din_vld=1, din_sop=1: pulse frame_err, set err_code=10, and accept the beat as pixel (0,0) of a new frame; remain in RECV.
REQ-024 Accepted beat with din_eop=1 at position (H_AP-1, V_AP-1): pulse frame_done, increment frame_cnt, go to IDLE.
REQ-025 Accepted beat with din_eop=1 at any other position: pixel still output, pulse frame_err, err_code=11, no frame_done, no frame_cnt change, go to IDLE.
REQ-026 Accepted beat at (H_AP-1, V_AP-1) with din_eop=0: pixel still output, pulse frame_err, err_code=11, go to IDLE.
REQ-027 If sop and eop occur on the same beat, the sop rules SHALL apply first; the eop is then checked against position (0,0). A good frame results only when H_AP=V_AP=1.
REQ-028 Outputs SHALL be registered with exactly 1 cycle of latency from an accepted input beat to pix_vld/pix_data/pix_x/pix_y and to the frame_done/frame_err pulses for that beat.
REQ-029 frame_done and frame_err SHALL never both be high in the same cycle.
REQ-030 No backpressure: every beat SHALL be processed in its own cycle at full rate (one beat per clock).

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, x=y=0, pix_vld=0, pix_data=0, pix_x=0, pix_y=0, frame_done=0, frame_err=0, err_code=00, frame_cnt=0, busy=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame silently, with no error pulse; after release the first beat SHALL be handled per IDLE rules.

Verification (H_AP=4, V_AP=3 unless stated)
REQ-033 Good frame: 12 beats, sop on beat 0, eop on beat 11, random 1-3 cycle gaps -> 12 pix_vld, (x,y) raster order (0,0)..(3,2); frame_done one cycle after beat 11; frame_cnt=1; frame_err never high.
REQ-034 Orphan beat then frame: 2 beats without sop, then a good frame -> two frame_err pulses with err_code=01, then a good frame with frame_cnt=1.
REQ-035 Early sop: sop on beat 6 of a frame, then 12 good beats -> frame_err with err_code=10 at beat 6; that beat is output as (0,0); frame_done after the following 11 beats.
REQ-036 Length errors: eop on beat 5 -> err_code=11, state IDLE, frame_cnt unchanged; separately, 12 beats with no eop -> err_code=11 after beat 11, no frame_done.
REQ-037 Wrap and reset: 256 good frames -> frame_cnt=0; then rst_n pulsed low mid-frame -> all outputs 0 immediately, no error pulse, and the next sop frame completes normally.
REQ-038 Default parameters: 2 frames of 1280x720 random RGB565, with 10-cycle gaps between lines -> 921600 pix_vld per frame, last pixel at (1279,719), two frame_done pulses.

Source files
------------

// File: rtl/frame_stream_rx_if.sv
// Pixel stream bundle: the raw beat input side and the accepted-pixel/status side.
interface frame_stream_rx_if;
  logic        din_sop;
  logic        din_eop;
  logic        din_vld;
  logic [15:0] din;
  logic        pix_vld;
  logic [15:0] pix_data;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [7:0]  frame_cnt;
  logic        busy;

  modport slave (
    input  din_sop, din_eop, din_vld, din,
    output pix_vld, pix_data, pix_x, pix_y,
           frame_done, frame_err, err_code, frame_cnt, busy
  );

  modport master (
    output din_sop, din_eop, din_vld, din,
    input  pix_vld, pix_data, pix_x, pix_y,
           frame_done, frame_err, err_code, frame_cnt, busy
  );
endinterface

// File: rtl/frame_stream_rx.sv
// Frame receiver: validates sop/eop framing of an RGB565 beat stream,
// tags each accepted pixel with its raster position, and reports
// frame completion and framing errors one cycle after the beat.
module frame_stream_rx #(
  parameter int H_AP = 1280,
  parameter int V_AP = 720
) (
  input logic             clk,
  input logic             rst_n,
  frame_stream_rx_if.slave bus
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [10:0] X_LAST = 11'(H_AP - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_AP - 1);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        pix_vld_q, pix_vld_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [10:0] pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        busy_q, busy_d;

  logic [10:0] cur_x;
  logic [9:0]  cur_y;
  logic        at_last;

  // Next-state: accept/drop each valid beat and derive position, pulses and status.
  // A sop beat is re-based to (0,0) before the eop/last-position check, so an
  // early sop and a length mismatch on the same beat produce one error pulse
  // whose code reflects the length mismatch.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pix_vld_d    = 1'b0;
    pix_data_d   = pix_data_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    frame_cnt_d  = frame_cnt_q;
    cur_x        = x_q;
    cur_y        = y_q;
    at_last      = 1'b0;

    if (bus.din_vld) begin
      if (state_q == IDLE && !bus.din_sop) begin
        frame_err_d = 1'b1;
        err_code_d  = 2'b01;
      end else begin
        if (bus.din_sop) begin
          cur_x = '0;
          cur_y = '0;
          if (state_q == RECV) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
          end
        end
        at_last    = (cur_x == X_LAST) && (cur_y == Y_LAST);
        pix_vld_d  = 1'b1;
        pix_data_d = bus.din;
        pix_x_d    = cur_x;
        pix_y_d    = cur_y;

        if (bus.din_eop || at_last) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
          if (bus.din_eop && at_last && !frame_err_d) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
          end else if (bus.din_eop != at_last) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b11;
          end
        end else begin
          state_d = RECV;
          if (cur_x == X_LAST) begin
            x_d = '0;
            y_d = cur_y + 10'd1;
          end else begin
            x_d = cur_x + 11'd1;
            y_d = cur_y;
          end
        end
      end
    end

    busy_d = (state_d == RECV);
  end

  // State and registered outputs; reset abandons any frame without a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      pix_vld_q    <= 1'b0;
      pix_data_q   <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
      frame_cnt_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pix_vld_q    <= pix_vld_d;
      pix_data_q   <= pix_data_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      frame_cnt_q  <= frame_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.pix_vld    = pix_vld_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_code   = err_code_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_frame_stream_rx.sv
// Scoreboard bench for frame_stream_rx with a small 4x3 frame geometry.
module tb_frame_stream_rx;
  localparam int H = 4;
  localparam int V = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  frame_stream_rx_if bus ();

  frame_stream_rx #(.H_AP(H), .V_AP(V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [15:0] d;
    logic [10:0] x;
    logic [9:0]  y;
    logic        done;
    logic        err;
    logic [1:0]  code;
    logic [7:0]  cnt;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: frame progress kept as a pixel index inside the frame.
  bit       m_in_frame = 0;
  int       m_n = 0;
  bit [1:0] m_code = 0;
  bit [7:0] m_cnt = 0;

  task automatic model_reset();
    m_in_frame = 0;
    m_n = 0;
    m_code = 0;
    m_cnt = 0;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Issue one beat (after an idle gap), pushing the response the model predicts.
  task automatic send_beat(bit sop, bit eop, logic [15:0] data, int gap);
    exp_t e;
    bit last;
    for (int g = 0; g < gap; g++) begin
      bus.din_vld = 1'b0;
      bus.din_sop = 1'($urandom);
      bus.din_eop = 1'($urandom);
      bus.din     = 16'($urandom);
      @(posedge clk); #2;
    end
    e = '{pv:0, d:0, x:0, y:0, done:0, err:0, code:0, cnt:0, busy:0};
    if (!m_in_frame && !sop) begin
      e.err = 1;
      m_code = 2'b01;
    end else begin
      if (sop) begin
        if (m_in_frame) begin
          e.err = 1;
          m_code = 2'b10;
        end
        m_n = 0;
      end
      e.pv = 1;
      e.d  = data;
      e.x  = 11'(m_n % H);
      e.y  = 10'(m_n / H);
      last = (m_n == H * V - 1);
      if (eop != last) begin
        e.err = 1;
        m_code = 2'b11;
      end else if (eop && !e.err) begin
        e.done = 1;
        m_cnt++;
      end
      if (eop || last) begin
        m_in_frame = 0;
      end else begin
        m_in_frame = 1;
        m_n++;
      end
    end
    e.code = m_code;
    e.cnt  = m_cnt;
    e.busy = m_in_frame;
    exp_q.push_back(e);
    bus.din_vld = 1'b1;
    bus.din_sop = sop;
    bus.din_eop = eop;
    bus.din     = data;
    @(posedge clk); #2;
    bus.din_vld = 1'b0;
  endtask

  task automatic idle(int n);
    bus.din_vld = 1'b0;
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  // beats: frame length; sop_at/eop_at: beat index carrying the flag (-1 = none).
  task automatic send_frame(int beats, int sop_at, int eop_at, int gmin, int gmax);
    for (int i = 0; i < beats; i++)
      send_beat(i == sop_at, i == eop_at, 16'($urandom), int'($urandom_range(gmax, gmin)));
  endtask

  // Monitor: every output event must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.pix_vld || bus.frame_done || bus.frame_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: pv=%0b done=%0b err=%0b with empty scoreboard",
                 bus.pix_vld, bus.frame_done, bus.frame_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.pix_vld !== e.pv || bus.frame_done !== e.done || bus.frame_err !== e.err ||
            bus.err_code !== e.code || bus.frame_cnt !== e.cnt || bus.busy !== e.busy ||
            (e.pv && (bus.pix_data !== e.d || bus.pix_x !== e.x || bus.pix_y !== e.y))) begin
          errors++;
          $display("FAIL event: got pv=%0b d=%h x=%0d y=%0d done=%0b err=%0b code=%0d cnt=%0d busy=%0b expected pv=%0b d=%h x=%0d y=%0d done=%0b err=%0b code=%0d cnt=%0d busy=%0b",
                   bus.pix_vld, bus.pix_data, bus.pix_x, bus.pix_y, bus.frame_done, bus.frame_err,
                   bus.err_code, bus.frame_cnt, bus.busy,
                   e.pv, e.d, e.x, e.y, e.done, e.err, e.code, e.cnt, e.busy);
        end
      end
    end
  end

  task automatic check_all_zero(string tag);
    check({tag, "_pix_vld"},    64'(bus.pix_vld),    64'd0);
    check({tag, "_pix_data"},   64'(bus.pix_data),   64'd0);
    check({tag, "_pix_xy"},     64'({bus.pix_x, bus.pix_y}), 64'd0);
    check({tag, "_pulses"},     64'({bus.frame_done, bus.frame_err}), 64'd0);
    check({tag, "_err_code"},   64'(bus.err_code),   64'd0);
    check({tag, "_frame_cnt"},  64'(bus.frame_cnt),  64'd0);
    check({tag, "_busy"},       64'(bus.busy),       64'd0);
  endtask

  initial begin
    bus.din_vld = 1'b0;
    bus.din_sop = 1'b0;
    bus.din_eop = 1'b0;
    bus.din     = '0;
    #1;
    check_all_zero("reset");
    #20;
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(2);

    // Good frame with 1-3 cycle gaps.
    send_frame(12, 0, 11, 1, 3);
    idle(3);
    check("good_cnt", 64'(bus.frame_cnt), 64'd1);

    // Orphan beats, then a good frame.
    model_reset();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    idle(1);
    send_frame(2, -1, -1, 0, 2);
    send_frame(12, 0, 11, 0, 2);
    idle(3);
    check("orphan_cnt", 64'(bus.frame_cnt), 64'd1);

    // Early sop at beat 6, then a complete frame starting at that sop.
    send_frame(6, 0, -1, 0, 1);
    send_frame(12, 0, 11, 0, 1);

    // Early eop, and a frame that reaches the last pixel without eop.
    send_frame(6, 0, 5, 0, 1);
    idle(2);
    check("early_eop_busy", 64'(bus.busy), 64'd0);
    send_frame(12, 0, -1, 0, 1);
    idle(2);
    check("no_eop_code", 64'(bus.err_code), 64'd3);

    // Same-beat sop+eop at the start of a frame is a length mismatch.
    send_frame(1, 0, 0, 0, 0);

    // Random mixture of framing flags.
    for (int i = 0; i < 300; i++)
      send_beat($urandom_range(7) == 0, $urandom_range(11) == 0, 16'($urandom),
                int'($urandom_range(2)));
    idle(3);

    // Counter wrap over 256 good frames (back-to-back beats).
    model_reset();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    idle(1);
    for (int f = 0; f < 256; f++)
      send_frame(12, 0, 11, 0, 0);
    idle(3);
    check("wrap_cnt", 64'(bus.frame_cnt), 64'd0);

    // Reset mid-frame: outputs clear immediately, no pulse, next frame is clean.
    send_frame(5, 0, -1, 0, 0);
    idle(2);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("post_reset_pulses", 64'({bus.frame_done, bus.frame_err}), 64'd0);
    send_frame(12, 0, 11, 0, 3);
    idle(3);
    check("post_reset_cnt", 64'(bus.frame_cnt), 64'd1);

    idle(4);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end
endmodule
